// File: rtl/imm_decode_pkg.sv
`default_nettype none
// ============================================================================
// Package : imm_decode_pkg
// Brief   : Immediate-type encoding, RISC-V opcode constants and a sign helper
//           shared by the immediate decode pipeline.
// Rev     : 1.0  initial release
// ============================================================================
package imm_decode_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

    localparam logic [6:0] c_opc_load     = 7'b0000011;
    localparam logic [6:0] c_opc_op_imm   = 7'b0010011;
    localparam logic [6:0] c_opc_jalr     = 7'b1100111;
    localparam logic [6:0] c_opc_store    = 7'b0100011;
    localparam logic [6:0] c_opc_branch   = 7'b1100011;
    localparam logic [6:0] c_opc_lui      = 7'b0110111;
    localparam logic [6:0] c_opc_auipc    = 7'b0010111;
    localparam logic [6:0] c_opc_jal      = 7'b1101111;
    localparam logic [6:0] c_opc_op_imm32 = 7'b0011011;
    localparam logic [6:0] c_opc_system   = 7'b1110011;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_decode_comb.sv
`default_nettype none
// ============================================================================
// Module : imm_decode_comb
// Brief  : Combinational RISC-V immediate extraction and opcode legality check.
// Config : IMMDEC_CSR_EN adds Z-type (CSR uimm) immediates for SYSTEM opcodes.
// Rev    : 1.0  initial release
// ============================================================================
module imm_decode_comb
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_type_e       o_imm_type,
    output logic            o_illegal
);

    logic [6:0]  w_opc;
    logic [31:0] w_imm;

    assign w_opc = i_instr[6:0];

    // Every format (Z included, whose bit 31 is zero) widens by sign-extending bit 31.
    assign o_imm = XLEN'($signed(w_imm));

    always_comb begin
        w_imm      = '0;
        o_imm_type = IMM_NONE;
        o_illegal  = 1'b0;
        case (w_opc)
            c_opc_load, c_opc_op_imm, c_opc_jalr: begin
                w_imm      = sext12(i_instr[31:20]);
                o_imm_type = IMM_I;
            end
            c_opc_op_imm32: begin
                if (XLEN == 64) begin
                    w_imm      = sext12(i_instr[31:20]);
                    o_imm_type = IMM_I;
                end else begin
                    o_illegal  = 1'b1;
                end
            end
            c_opc_store: begin
                w_imm      = sext12({i_instr[31:25], i_instr[11:7]});
                o_imm_type = IMM_S;
            end
            c_opc_branch: begin
                w_imm      = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
                o_imm_type = IMM_B;
            end
            c_opc_lui, c_opc_auipc: begin
                w_imm      = {i_instr[31:12], 12'b0};
                o_imm_type = IMM_U;
            end
            c_opc_jal: begin
                w_imm      = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
                o_imm_type = IMM_J;
            end
            c_opc_system: begin
`ifdef IMMDEC_CSR_EN
                if (i_instr[14]) begin
                    w_imm      = {27'b0, i_instr[19:15]};
                    o_imm_type = IMM_Z;
                end
`endif
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module : imm_decode_pipe
// Brief  : One-cycle immediate decode stage with output + skid register,
//          valid/ready on both sides and a flush input. XLEN must be 32 or 64.
// Config : IMMDEC_CSR_EN enables CSR (Z-type) immediates in the decoder.
// Rev    : 1.0  initial release
// ============================================================================
module imm_decode_pipe
    import imm_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [31:0]      i_instr,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_imm_type,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_type_e        typ;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] w_dec_imm;
    imm_type_e       w_dec_type;
    logic            w_dec_ill;
    entry_t          w_in;
    entry_t          r_out;
    entry_t          r_skid;
    logic            r_out_valid;
    logic            r_skid_valid;
    logic            w_accept;
    logic            w_take;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_comb (
        .i_instr    (i_instr),
        .o_imm      (w_dec_imm),
        .o_imm_type (w_dec_type),
        .o_illegal  (w_dec_ill)
    );

    assign w_in = '{imm: w_dec_imm, typ: w_dec_type, ill: w_dec_ill, tag: i_tag};

    // Ready depends only on the skid flop (and reset), never on o_ready.
    assign i_ready  = ~r_skid_valid & ~i_rst;
    assign w_accept = i_valid & i_ready;
    assign w_take   = ~r_out_valid | o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_take) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out        <= w_in;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_in;
            r_skid_valid <= 1'b1;
        end
    end

    assign o_valid    = r_out_valid;
    assign o_imm      = r_out.imm;
    assign o_imm_type = r_out.typ;
    assign o_illegal  = r_out.ill;
    assign o_tag      = r_out.tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_imm_decode_pipe
// Brief  : Scoreboard bench driving a 32-bit and a 64-bit instance in lockstep.
// Rev    : 1.0  initial release
// ============================================================================
module tb_imm_decode_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_rdy;
    logic [31:0] instr;
    logic [4:0]  tag;

    logic        rdy32, rdy64, ov32, ov64, il32, il64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  ty32, ty64;
    logic [4:0]  tg32, tg64;

    always #5 clk = ~clk;

    imm_decode_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .i_ready(rdy32),
        .i_instr(instr), .i_tag(tag), .o_valid(ov32), .o_ready(out_rdy), .o_imm(imm32),
        .o_imm_type(ty32), .o_illegal(il32), .o_tag(tg32));

    imm_decode_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .i_ready(rdy64),
        .i_instr(instr), .i_tag(tag), .o_valid(ov64), .o_ready(out_rdy), .o_imm(imm64),
        .o_imm_type(ty64), .o_illegal(il64), .o_tag(tg64));

    exp_t q32[$];
    exp_t q64[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] v_instr[13];
    logic [31:0] v_imm32[13];
    logic [2:0]  v_ty32[13];
    logic        v_il32[13];
    logic [63:0] v_imm64[13];
    logic [2:0]  v_ty64[13];
    logic        v_il64[13];

    task automatic set_vec(input int i, input logic [31:0] ins,
                           input logic [31:0] i32, input logic [2:0] t32, input logic l32,
                           input logic [63:0] i64, input logic [2:0] t64, input logic l64);
        v_instr[i] = ins;
        v_imm32[i] = i32; v_ty32[i] = t32; v_il32[i] = l32;
        v_imm64[i] = i64; v_ty64[i] = t64; v_il64[i] = l64;
    endtask

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every output handshake; also check hold stability.
    exp_t        e32, e64;
    logic        held_v = 1'b0;
    logic [40:0] held_p;
    always @(negedge clk) begin
        if (!rst) begin
            if (ov32 && out_rdy) begin
                if (q32.size() == 0) chk("unexpected_out32", 80'(tg32), 80'h3ff);
                else begin
                    e32 = q32.pop_front();
                    chk("out32", 80'({imm32, ty32, il32, tg32}),
                        80'({e32.imm[31:0], e32.typ, e32.ill, e32.tag}));
                end
            end
            if (ov64 && out_rdy) begin
                if (q64.size() == 0) chk("unexpected_out64", 80'(tg64), 80'h3ff);
                else begin
                    e64 = q64.pop_front();
                    chk("out64", 80'({imm64, ty64, il64, tg64}),
                        80'({e64.imm, e64.typ, e64.ill, e64.tag}));
                end
            end
            if (held_v && ov32)
                chk("hold32", 80'({imm32, ty32, il32, tg32}), 80'(held_p));
            held_v = ov32 && !out_rdy;
            held_p = {imm32, ty32, il32, tg32};
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send(input int idx, input logic [4:0] t, output int cyc);
        logic acc;
        exp_t e;
        cyc      = 0;
        in_valid = 1'b1;
        instr    = v_instr[idx];
        tag      = t;
        do begin
            @(negedge clk);
            acc = rdy32 & rdy64;
            @(posedge clk);
            #1;
            cyc++;
        end while (!acc && cyc < 50);
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 80'(cyc), 80'(0));
        else begin
            e.imm = {32'b0, v_imm32[idx]}; e.typ = v_ty32[idx]; e.ill = v_il32[idx]; e.tag = t;
            q32.push_back(e);
            e.imm = v_imm64[idx]; e.typ = v_ty64[idx]; e.ill = v_il64[idx];
            q64.push_back(e);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((q32.size() != 0 || q64.size() != 0) && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain", 80'(q32.size() + q64.size()), 80'(0));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int c;

    initial begin
        set_vec(0,  32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        set_vec(1,  32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        set_vec(2,  32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
`ifdef IMMDEC_CSR_EN
        set_vec(3,  32'h300FD073, 32'h0000001F, 3'd6, 1'b0, 64'h000000000000001F, 3'd6, 1'b0);
`else
        set_vec(3,  32'h300FD073, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0);
`endif
        set_vec(4,  32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1);
        set_vec(5,  32'hFE20AC23, 32'hFFFFFFF8, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0);
        set_vec(6,  32'h0010006F, 32'h00000800, 3'd5, 1'b0, 64'h0000000000000800, 3'd5, 1'b0);
        set_vec(7,  32'h0051009B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000005, 3'd1, 1'b0);
        set_vec(8,  32'h12345137, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0);
        set_vec(9,  32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0);
        set_vec(10, 32'h7FF02083, 32'h000007FF, 3'd1, 1'b0, 64'h00000000000007FF, 3'd1, 1'b0);
        set_vec(11, 32'h800080E7, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0);
        set_vec(12, 32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_rdy = 1'b0; instr = '0; tag = '0;
        cycles(3);
        chk("reset32", 80'({ov32, rdy32, imm32, ty32, il32, tg32}), 80'(0));
        chk("reset64", 80'({ov64, rdy64, imm64, ty64, il64, tg64}), 80'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 80'({rdy32, rdy64}), 80'(2'b11));
        @(posedge clk); #1;

        // Latency and full-rate streaming
        out_rdy = 1'b1;
        send(0, 5'd1, c);
        chk("latency", 80'({ov32, ov64}), 80'(2'b11));
        for (int i = 1; i < 13; i++) begin
            send(i, 5'(i + 1), c);
            chk("throughput", 80'(c), 80'(1));
        end
        drain();

        // Backpressure: o_ready low for three cycles while four items stream in
        out_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(i, 5'(i + 1), c);
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                chk("ready_falls", 80'({rdy32, rdy64}), 80'(0));
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        drain();

        // Flush with both registers full and a pending input
        out_rdy = 1'b0;
        send(4, 5'd5, c);
        send(5, 5'd6, c);
        in_valid = 1'b1; instr = v_instr[6]; tag = 5'd7; flush = 1'b1;
        cycles(1);
        flush = 1'b0; in_valid = 1'b0;
        q32.delete(); q64.delete();
        chk("flush_full", 80'({ov32, ov64, rdy32, rdy64}), 80'(4'b0011));

        // Flush in the same cycle an input is accepted
        send(7, 5'd8, c);
        in_valid = 1'b1; instr = v_instr[8]; tag = 5'd9; flush = 1'b1;
        cycles(1);
        flush = 1'b0; in_valid = 1'b0;
        q32.delete(); q64.delete();
        chk("flush_accept", 80'({ov32, ov64, rdy32, rdy64}), 80'(4'b0011));
        out_rdy = 1'b1;
        cycles(4);
        send(6, 5'd10, c);
        drain();

        // Reset mid-transfer beats a concurrent flush
        out_rdy = 1'b0;
        send(9, 5'd11, c);
        send(10, 5'd12, c);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; instr = v_instr[11]; tag = 5'd13;
        cycles(1);
        chk("reset_mid32", 80'({ov32, rdy32, imm32, ty32, il32, tg32}), 80'(0));
        chk("reset_mid64", 80'({ov64, rdy64, imm64, ty64, il64, tg64}), 80'(0));
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        q32.delete(); q64.delete();
        @(negedge clk);
        chk("ready_after_mid_reset", 80'({rdy32, rdy64}), 80'(2'b11));
        @(posedge clk); #1;
        out_rdy = 1'b1;
        cycles(4);
        send(12, 5'd14, c);
        drain();
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL provide parameter TAG_W, default 5, width of the opaque sideband tag carried alongside each instruction.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port i_flush, input, 1, pipeline flush request from the hazard unit.
REQ-006 SHALL have ports i_valid (input, 1), i_ready (output, 1), i_instr (input, 32) and i_tag (input, TAG_W) as the upstream handshake and payload.
REQ-007 SHALL have ports o_valid (output, 1), o_ready (input, 1), o_imm (output, XLEN), o_imm_type (output, 3), o_illegal (output, 1) and o_tag (output, TAG_W) as the downstream handshake and payload.

Function
REQ-008 Transfers SHALL occur only on cycles where valid and ready are both high.
REQ-009 Opcode decode: 0000011, 0010011 and 1100111 SHALL be I-type; 0100011 S; 1100011 B; 0110111 and 0010111 U; 1101111 J.
REQ-010 Opcode 0011011 SHALL be I-type when XLEN==64; when XLEN==32 it SHALL be unrecognised.
REQ-011 I, S, B and J immediates SHALL be sign-extended from instruction bit 31 to XLEN; B and J SHALL have bit 0 forced to 0.
REQ-012 U-type SHALL be {instr[31:12], 12'b0} sign-extended from bit 31 to XLEN.
REQ-013 An unrecognised opcode SHALL give o_imm=0, o_imm_type=NONE and o_illegal=1; every other opcode SHALL give o_illegal=0.
REQ-014 Latency SHALL be exactly 1 cycle: an input accepted in cycle N with the pipe empty SHALL appear on o_valid in cycle N+1.
REQ-015 Storage SHALL be one output register plus one skid register.
REQ-016 i_ready SHALL equal !skid_valid and SHALL be registered, with no combinational path from o_ready.
REQ-017 If an input is accepted while the output register is valid and o_ready is low, it SHALL be stored in the skid register.
REQ-018 When the output is consumed, the output register SHALL load from the skid register if the skid register is valid, otherwise from the accepted input, otherwise become invalid.
REQ-019 Order SHALL be strictly FIFO; no instruction SHALL be dropped or duplicated; throughput SHALL be 1 per cycle while o_ready is high.
REQ-020 i_flush SHALL clear both valid bits in the next cycle, and an input accepted in the flush cycle SHALL be discarded.
REQ-021 i_ready SHALL be 1 on the cycle after a flush.
REQ-022 Payload outputs SHALL hold stable while o_valid=1 and o_ready=0.

Reset
REQ-023 While i_rst is high: o_valid=0, the skid register is invalid, i_ready=0, o_imm=0, o_imm_type=NONE, o_illegal=0 and o_tag=0.
REQ-024 i_ready SHALL be 1 on the first cycle after i_rst deasserts.
REQ-025 i_rst asserted mid-transfer SHALL discard all held entries; i_rst SHALL take priority over i_flush.

Configuration
REQ-026 Macro IMMDEC_CSR_EN SHALL gate CSR immediate support.
REQ-027 With IMMDEC_CSR_EN defined, opcode 1110011 with funct3[2]=1 SHALL give a Z-type immediate: instr[19:15] zero-extended to XLEN, with o_illegal=0.
REQ-028 Without IMMDEC_CSR_EN, opcode 1110011 SHALL give o_imm=0, o_imm_type=NONE and o_illegal=0, because SYSTEM is a legal opcode handled elsewhere.

Structure
REQ-029 Package imm_decode_pkg SHALL hold:
- imm_type_e (3 bits): NONE=0, I=1, S=2, B=3, U=4, J=5, Z=6.
- the opcode localparams.
REQ-030 The combinational decode SHALL be a sub-module imm_decode_comb (instr in; imm, type, illegal out), instantiated once at the input side; the registers and skid logic SHALL live in imm_decode_pipe.

Verification
REQ-031 XLEN=32, 0xFFF00093 (addi -1), o_ready=1 -> next cycle o_imm=0xFFFFFFFF, type I, illegal=0.
REQ-032 0xFE000EE3 (beq -4) -> o_imm=0xFFFFFFFC, type B; XLEN=64 -> 0xFFFFFFFFFFFFFFFC.
REQ-033 XLEN=64, 0x800000B7 (lui 0x80000) -> o_imm=0xFFFFFFFF80000000, type U.
REQ-034 Back-to-back inputs, tags 1..4, o_ready low for 3 cycles -> i_ready falls after 2 accepts; outputs tags 1,2,3,4 in order, with no loss.
REQ-035 Both registers full plus a new accept, with i_flush=1 -> o_valid=0 and i_ready=1 next cycle; no stale tag ever appears.
REQ-036 0x300FD073 (csrrwi imm 31) -> with IMMDEC_CSR_EN: o_imm=31, type Z; without it: o_imm=0, type NONE, illegal=0; opcode 0x7F -> illegal=1.
